commit_trace_fifo: RTL and testbench

Captures the datapath's per-cycle commit trace, the `(PCResult, WriteData)` pair, into a small on-chip FIFO. A downstream reader drains the FIFO over a valid/ready handshake. The block sits beside `DataPath`, observing its `PCResult` and `writedata` outputs, and feeds a trace port, a checker, or a UART dumper. It is the consuming end of the datapath's result interface and gives benches and hardware a lossless-until-full record of execution.

---
 rtl/commit_trace_fifo.sv | 92 +++++++++
 tb/tb_commit_trace_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// Commit-trace capture FIFO: stores {PCResult, WriteData} per pushed cycle, drained over valid/ready.
// Optional build macro COMMIT_TRACE_DEDUP_EN suppresses pushes that repeat the last-seen PC.
module commit_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       PCResult,
  input  logic [31:0]       WriteData,
  input  logic              CaptureEn,
  output logic              Trace_Valid,
  input  logic              Trace_Ready,
  output logic [31:0]       Trace_PC,
  output logic [31:0]       Trace_Data,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

`ifdef COMMIT_TRACE_DEDUP_EN
  logic [31:0] last_pc;
  logic        last_valid;

  // Last-seen PC tracks every CaptureEn edge, even when the push itself is dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_pc    <= '0;
      last_valid <= 1'b0;
    end else if (CaptureEn) begin
      last_pc    <= PCResult;
      last_valid <= 1'b1;
    end
  end

  always_comb begin
    push_req = CaptureEn && (!last_valid || (PCResult != last_pc));
  end
`else
  always_comb begin
    push_req = CaptureEn;
  end
`endif

  always_comb begin
    Trace_Valid = (count != '0);
    full        = (count == FULL_COUNT);
    pop         = Trace_Valid && Trace_Ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && push) mem[wptr] <= {PCResult, WriteData};
  end

  always_comb begin
    Trace_PC   = mem[rptr][63:32];
    Trace_Data = mem[rptr][31:0];
    Count      = count;
    Overflow   = overflow;
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model (honours COMMIT_TRACE_DEDUP_EN).
module tb_commit_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [31:0]       PCResult = '0;
  logic [31:0]       WriteData = '0;
  logic              CaptureEn = 1'b0;
  logic              Trace_Valid;
  logic              Trace_Ready = 1'b0;
  logic [31:0]       Trace_PC;
  logic [31:0]       Trace_Data;
  logic [ADDR_W:0]   Count;
  logic              Overflow;

  commit_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst(Rst), .PCResult(PCResult), .WriteData(WriteData),
    .CaptureEn(CaptureEn), .Trace_Valid(Trace_Valid), .Trace_Ready(Trace_Ready),
    .Trace_PC(Trace_PC), .Trace_Data(Trace_Data), .Count(Count), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {pc, data} entries plus the sticky overflow flag.
  logic [63:0] mq[$];
  bit          movf = 1'b0;
  logic [31:0] mlpc = '0;
  bit          mlv  = 1'b0;

  typedef struct {
    bit          rst;
    bit          cap;
    bit          rdy;
    logic [31:0] pc;
    logic [31:0] data;
    bit          e_valid;
    int          e_count;
    bit          e_ovf;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit cap, input bit rdy,
                            input logic [31:0] pc, input logic [31:0] data);
    bit pop;
    bit cand;
    if (rst) begin
      mq.delete();
      movf = 1'b0;
      mlv  = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      cand = cap;
`ifdef COMMIT_TRACE_DEDUP_EN
      cand = cap && (!mlv || pc != mlpc);
      if (cap) begin
        mlpc = pc;
        mlv  = 1'b1;
      end
`endif
      if (pop) void'(mq.pop_front());
      if (cand) begin
        if (mq.size() < DEPTH) mq.push_back({pc, data});
        else movf = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit cap, input bit rdy,
                     input logic [31:0] pc, input logic [31:0] data);
    Rst = rst; CaptureEn = cap; Trace_Ready = rdy; PCResult = pc; WriteData = data;
    model_step(rst, cap, rdy, pc, data);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_model();
    chk("valid", 64'(Trace_Valid), 64'(mq.size() != 0));
    chk("count", 64'(Count), 64'(mq.size()));
    chk("overflow", 64'(Overflow), 64'(movf));
    if (mq.size() != 0) begin
      chk("head_pc", 64'(Trace_PC), 64'(mq[0][63:32]));
      chk("head_data", 64'(Trace_Data), 64'(mq[0][31:0]));
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    check_model();
  endtask

  vec_t vecs[10];
  logic [31:0] exp_pcs[$];

  initial begin
    // Vector table: reset, single push/pop, hold under backpressure, push+pop together.
    vecs[0] = '{1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0};
    vecs[1] = '{1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0};
    vecs[2] = '{0, 1, 0, 32'h4,  32'h2A, 1, 1, 0, 32'h4,  32'h2A};
    vecs[3] = '{0, 0, 1, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0};
    vecs[4] = '{0, 0, 1, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0};
    vecs[5] = '{0, 1, 0, 32'h10, 32'h11, 1, 1, 0, 32'h10, 32'h11};
    vecs[6] = '{0, 1, 0, 32'h14, 32'h22, 1, 2, 0, 32'h10, 32'h11};
    vecs[7] = '{0, 1, 1, 32'h18, 32'h33, 1, 2, 0, 32'h14, 32'h22};
    vecs[8] = '{0, 0, 1, 32'h0,  32'h0,  1, 1, 0, 32'h18, 32'h33};
    vecs[9] = '{0, 0, 1, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0};

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].rst, vecs[i].cap, vecs[i].rdy, vecs[i].pc, vecs[i].data);
      chk($sformatf("vec%0d_valid", i), 64'(Trace_Valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 64'(Count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_ovf", i), 64'(Overflow), 64'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), 64'(Trace_PC), 64'(vecs[i].e_pc));
        chk($sformatf("vec%0d_data", i), 64'(Trace_Data), 64'(vecs[i].e_data));
      end
    end

    // Fill past capacity: 17th push dropped, overflow sticky, order kept.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'(4 * i), 32'(i + 100));
      check_model();
    end
    chk("fill_count", 64'(Count), 64'(DEPTH));
    chk("fill_ovf", 64'(Overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", 64'(Trace_PC), 64'(4 * i));
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
      check_model();
    end
    chk("drain_empty", 64'(Trace_Valid), 64'd0);
    chk("drain_ovf_sticky", 64'(Overflow), 64'd1);

    // Full with simultaneous push and pop: accepted, no overflow, new entry last.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'(i));
    chk("full_count", 64'(Count), 64'(DEPTH));
    cyc(1'b0, 1'b1, 1'b1, 32'h500, 32'h5A5A);
    chk("fullpp_count", 64'(Count), 64'(DEPTH));
    chk("fullpp_ovf", 64'(Overflow), 64'd0);
    chk("fullpp_head", 64'(Trace_PC), 64'h104);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("fullpp_last_pc", 64'(Trace_PC), 64'h500);
    chk("fullpp_last_data", 64'(Trace_Data), 64'h5A5A);
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    check_model();

    // Streaming: one prefill, then 40 push+pop cycles; pointers wrap twice.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'h1000, 32'hD000);
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 32'hD000 + 32'(i));
      chk("stream_count", 64'(Count), 64'd1);
      chk("stream_pc", 64'(Trace_PC), 64'(32'h1000 + 32'(4 * i)));
      chk("stream_data", 64'(Trace_Data), 64'(32'hD000 + 32'(i)));
    end

    // Reset mid-operation with count 5 and overflow set, push requested in the reset cycle.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 32'h2000 + 32'(4 * i), 32'(i));
    for (int i = 0; i < DEPTH - 5; i++) cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("pre_rst_count", 64'(Count), 64'd5);
    chk("pre_rst_ovf", 64'(Overflow), 64'd1);
    cyc(1'b1, 1'b1, 1'b1, 32'h3000, 32'h1);
    chk("midrst_count", 64'(Count), 64'd0);
    chk("midrst_ovf", 64'(Overflow), 64'd0);
    chk("midrst_valid", 64'(Trace_Valid), 64'd0);

    // Dedup sequence: repeated PCs collapse only when the macro is defined.
    do_reset();
`ifdef COMMIT_TRACE_DEDUP_EN
    exp_pcs = '{32'h8, 32'hC, 32'h8};
`else
    exp_pcs = '{32'h8, 32'h8, 32'h8, 32'hC, 32'hC, 32'h8};
`endif
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h2);
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h3);
    cyc(1'b0, 1'b1, 1'b0, 32'hC, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 32'hC, 32'h5);
    cyc(1'b0, 1'b1, 1'b0, 32'h8, 32'h6);
    chk("dedup_count", 64'(Count), 64'(exp_pcs.size()));
    foreach (exp_pcs[i]) begin
      chk("dedup_pc", 64'(Trace_PC), 64'(exp_pcs[i]));
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
    end
    chk("dedup_empty", 64'(Trace_Valid), 64'd0);

    // Randomized traffic; ready bias alternates so the FIFO both fills and drains.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r, c, d;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 3) != 0);
      if ((i / 250) % 2 == 0) d = ($urandom_range(0, 3) == 0);
      else                    d = ($urandom_range(0, 3) != 0);
      cyc(r, c, d, 32'($urandom_range(0, 3)) * 4, $urandom);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
